// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the shared-bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_OWN   = 2'd2
  } state_t;

  localparam int IDX_W = 3;

  localparam logic [IDX_W-1:0] REQ_PC   = 3'd0;
  localparam logic [IDX_W-1:0] REQ_SP   = 3'd1;
  localparam logic [IDX_W-1:0] REQ_ALU  = 3'd2;
  localparam logic [IDX_W-1:0] REQ_REGS = 3'd3;
  localparam logic [IDX_W-1:0] REQ_MEM  = 3'd4;

  // Index following idx, wrapping from n-1 back to 0.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/bus_arbiter_arb_pick.sv
// Combinational masked priority selector: first requester at or after 'start',
// skipping 'excl' whenever any other requester is active.
module arb_pick
  import bus_arbiter_pkg::*;
#(
  parameter int N_REQ = 5
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  input  logic [IDX_W-1:0] excl,
  input  logic             excl_en,
  output logic [N_REQ-1:0] winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             valid
);

  localparam logic [IDX_W:0] N_L = (IDX_W + 1)'(N_REQ);

  logic [N_REQ-1:0]   excl_mask;
  logic [N_REQ-1:0]   others;
  logic [N_REQ-1:0]   masked;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   rot_win;
  logic [2*N_REQ-1:0] dbl_req;
  logic [2*N_REQ-1:0] dbl_win;
  logic [IDX_W-1:0]   offset;
  logic [IDX_W:0]     sum;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign excl_mask[gi] = excl_en && (excl == IDX_W'(gi));
    end
  endgenerate

  assign others = req & ~excl_mask;
  assign masked = (|others) ? others : req;

  // Rotate so the search always starts at bit 0, then rotate the winner back.
  assign dbl_req = {masked, masked} >> start;
  assign rot     = dbl_req[N_REQ-1:0];

  always_comb begin
    rot_win = '0;
    offset  = '0;
    valid   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!valid && rot[i]) begin
        valid      = 1'b1;
        rot_win[i] = 1'b1;
        offset     = IDX_W'(i);
      end
    end
  end

  assign dbl_win    = {rot_win, rot_win} << start;
  assign winner     = dbl_win[2*N_REQ-1:N_REQ];
  assign sum        = {1'b0, start} + {1'b0, offset};
  assign winner_idx = (sum >= N_L) ? IDX_W'(sum - N_L) : sum[IDX_W-1:0];

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter with guard cycles on ownership change and a hold limit.
// Define BUS_ARBITER_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_REQ    = 5,
  parameter int GUARD    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] oe,
  output logic [2:0]       owner,
  output logic             busy
);

  localparam int              HOLD_W   = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'((MAX_HOLD == 0) ? 1 : MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [1:0]        GUARD_L  = 2'(GUARD);

  state_t            state;
  logic [1:0]        guard_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [IDX_W-1:0]  start;
  logic [N_REQ-1:0]  pick_win;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              owner_req;
  logic              others;
  logic              hold_hit;
  logic              drop;
  logic              regrant;

  assign owner_req = |(req & gnt);
  assign others    = |(req & ~gnt);
  assign hold_hit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_SAT);

  // Ownership ends when the owner lets go, or when it has used up its hold
  // budget while someone else is waiting.
  assign drop    = ((state == ST_GUARD) && !owner_req) ||
                   ((state == ST_OWN) && (!owner_req || (hold_hit && others)));
  assign regrant = ((state == ST_IDLE) || drop) && pick_valid;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (regrant) begin
      rr_ptr <= wrap_inc(pick_idx, N_REQ);
    end
  end

  assign start = rr_ptr;
`else
  assign start = '0;
`endif

  arb_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (req),
    .start      (start),
    .excl       (owner),
    .excl_en    (state != ST_IDLE),
    .winner     (pick_win),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      oe        <= '0;
      owner     <= '0;
      busy      <= 1'b0;
      guard_cnt <= '0;
      hold_cnt  <= '0;
    end else if (regrant) begin
      gnt   <= pick_win;
      owner <= pick_idx;
      busy  <= 1'b1;
      if (GUARD > 0) begin
        state     <= ST_GUARD;
        oe        <= '0;
        guard_cnt <= 2'd1;
        hold_cnt  <= '0;
      end else begin
        state     <= ST_OWN;
        oe        <= pick_win;
        guard_cnt <= '0;
        hold_cnt  <= HOLD_ONE;
      end
    end else if (drop) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      oe        <= '0;
      owner     <= '0;
      busy      <= 1'b0;
      guard_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        ST_GUARD: begin
          if (guard_cnt >= GUARD_L) begin
            state     <= ST_OWN;
            oe        <= gnt;
            guard_cnt <= '0;
            hold_cnt  <= HOLD_ONE;
          end else begin
            guard_cnt <= guard_cnt + 2'd1;
          end
        end
        ST_OWN: begin
          if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + HOLD_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 5, number of shared-bus requesters (index 0 = PC, 1 = SP, 2 = ALU, 3 = REGS, 4 = MEM).
REQ-002 Parameter GUARD, default 1, dead cycles (0..3) with all output enables low on every ownership change.
REQ-003 Parameter MAX_HOLD, default 8, max consecutive owned cycles before forced release when others wait; 0 = unlimited.
REQ-004 clk  input  1  single system clock, rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_REQ  level request per requester; held while bus is wanted.
REQ-007 gnt  output  N_REQ  one-hot-or-zero registered grant.
REQ-008 oe  output  N_REQ  one-hot-or-zero tristate enable; the only permission to drive the bus.
REQ-009 owner  output  3  index of granted requester; 0 when idle.
REQ-010 busy  output  1  high whenever gnt is non-zero.

Function
REQ-011 FSM states SHALL be IDLE, GUARD, OWN; all outputs registered.
REQ-012 IDLE: any req high -> gnt = winner next edge; go to GUARD (GUARD>0) or OWN (GUARD=0).
REQ-013 GUARD: gnt held, oe = 0, count GUARD cycles, then OWN.
REQ-014 OWN: oe = gnt; hold counter increments each cycle from 1.
REQ-015 OWN, owner req low, others pending -> new winner granted next edge, enter GUARD; none pending -> IDLE, gnt = 0.
REQ-016 OWN, hold counter = MAX_HOLD (MAX_HOLD != 0), another req pending -> forced handover as REQ-015 even if owner req still high.
REQ-017 OWN, MAX_HOLD reached, no other req -> keep ownership, hold counter saturates at MAX_HOLD.
REQ-018 GUARD, owner drops req -> abandon grant; re-arbitrate next edge (IDLE if none pending, else new GUARD).
REQ-019 Winner selection excludes the current/outgoing owner whenever any other req is high.
REQ-020 Latency: req rises in IDLE at edge n -> gnt at edge n+1, oe at edge n+1+GUARD.
REQ-021 At most one oe bit high in any cycle; oe never high during GUARD or the cycle gnt changes.
REQ-022 Requests arriving while bus owned SHALL NOT alter gnt/oe until release or forced handover.

Reset
REQ-023 reset low SHALL asynchronously force state IDLE, gnt = 0, oe = 0, owner = 0, busy = 0, counters = 0, round-robin pointer = 0.
REQ-024 Reset mid-ownership SHALL drop oe in the same cycle without a guard period; arbitration resumes from first clk edge after reset high.

Configuration
REQ-025 Macro BUS_ARBITER_ROUND_ROBIN_EN defined: round-robin; search starts at index after last owner, wrapping N_REQ-1 -> 0.
REQ-026 Macro undefined: fixed priority, lowest requesting index wins (subject to REQ-019); no pointer register.

Structure
REQ-027 Shared package SHALL hold the state enum (IDLE/GUARD/OWN) and requester index constants (REQ_PC..REQ_MEM).
REQ-028 One sub-module arb_pick: combinational masked priority selector (req, start index, exclude index -> one-hot winner, valid).

Verification
REQ-029 Bench with N_REQ=5, GUARD=1, MAX_HOLD=8 SHALL cover:
- req=00001 at edge 0 -> gnt=00001 edge 1, oe=00001 edge 2, owner=0.
- Owner 0, req=00101 then req[0] low -> gnt=00100 next edge, oe=00000 one cycle, then oe=00100.
- req=00011 held 20 cycles, round-robin -> ownership alternates 0,1 every 8 owned cycles plus 1 guard; fixed priority same alternation via REQ-019.
- req=10000 only, held 20 cycles -> gnt stays 10000, no guard insertion after cycle 8.
- req[2] dropped during GUARD with req=01000 pending -> gnt=01000 next edge, oe for bit 2 never asserted.
- reset low mid-OWN -> gnt/oe/busy zero immediately; reset high with req=00010 -> gnt=00010 first edge.
